// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    import fetch_pkg::*;

    logic               req;
    logic [INSTR_W-1:0] addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register that parks a fetched instruction while IF/ID is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               unload,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [INSTR_W-1:0] load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc
);

    // Clear (flush) wins over load so a redirect never leaves stale data behind.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: imem request FSM, IF/ID pipeline register and next-PC select.
// state  | meaning
// S_IDLE | first cycle out of reset, no request
// S_REQ  | request outstanding at pc, waiting for ack
// S_HOLD | response parked in skid while IF/ID is stalled, no request
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_next,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_target,
    input  logic               stall,
    fetch_stage_if.master      imem,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc,
    output logic [INSTR_W-1:0] if_pc_plus4
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic               accept;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_unload;
    logic               ifid_load_mem;
    logic               ifid_load_skid;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [INSTR_W-1:0] skid_pc;

    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        imem.req       = 1'b0;
        accept         = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        skid_unload    = 1'b0;
        ifid_load_mem  = 1'b0;
        ifid_load_skid = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                imem.req = 1'b1;
                accept   = imem.ack && !redirect_valid;
                if (accept) begin
                    if (stall) begin
                        skid_load = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        ifid_load_mem = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    skid_unload    = 1'b1;
                    ifid_load_skid = skid_valid;
                    state_nxt      = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A flush beats stall and any response arriving in the same cycle.
        if (redirect_valid) begin
            state_nxt      = S_REQ;
            skid_clear     = 1'b1;
            skid_load      = 1'b0;
            skid_unload    = 1'b0;
            ifid_load_mem  = 1'b0;
            ifid_load_skid = 1'b0;
        end

        // Reset is synchronous, so outputs are gated here to look idle immediately.
        if (rst) begin
            state_nxt      = S_IDLE;
            imem.req       = 1'b0;
            accept         = 1'b0;
            skid_load      = 1'b0;
            skid_clear     = 1'b0;
            skid_unload    = 1'b0;
            ifid_load_mem  = 1'b0;
            ifid_load_skid = 1'b0;
        end
    end

    always_comb begin
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (accept) begin
            pc_next = pc_plus4(pc);
        end else begin
            pc_next = pc;
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .unload     (skid_unload),
        .load_instr (imem.rdata),
        .load_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (ifid_load_mem) begin
            if_valid    <= 1'b1;
            if_instr    <= imem.rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4(pc);
        end else if (ifid_load_skid) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= pc_plus4(skid_pc);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based behavioural model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    fetch_stage_if imem_bus ();

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem            (imem_bus),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model: fetching is allowed one cycle after reset release whenever nothing is parked.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      parked[$];
    bit          m_started = 1'b0;
    bit          chk_en    = 1'b0;
    logic        m_valid   = 1'b0;
    logic [31:0] m_instr   = 32'h0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_pc4     = 32'h0;

    bit          e_fetch;
    bit          e_accept;
    logic [31:0] e_next;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b0;
            parked.delete();
            m_valid   = 1'b0;
            m_instr   = 32'h0;
            m_pc      = 32'h0;
            m_pc4     = 32'h0;
            chk_en    = 1'b1;
        end else begin
            e_fetch = m_started && (parked.size() == 0);
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_instr = 32'h0;
                parked.delete();
            end else if (e_fetch && imem_bus.ack) begin
                if (stall) begin
                    parked.push_back('{instr: imem_bus.rdata, pc: pc});
                end else begin
                    m_valid = 1'b1;
                    m_instr = imem_bus.rdata;
                    m_pc    = pc;
                    m_pc4   = pc + 32'd4;
                end
            end else if (parked.size() != 0 && !stall) begin
                m_valid = 1'b1;
                m_instr = parked[0].instr;
                m_pc    = parked[0].pc;
                m_pc4   = parked[0].pc + 32'd4;
                parked.delete();
            end
            m_started = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_fetch  = !rst && m_started && (parked.size() == 0);
            e_accept = e_fetch && imem_bus.ack && !redirect_valid;
            if (rst)                 e_next = 32'h0;
            else if (redirect_valid) e_next = redirect_target;
            else if (e_accept)       e_next = pc + 32'd4;
            else                     e_next = pc;
            chk("imem_req",    32'(imem_bus.req), 32'(e_fetch));
            chk("imem_addr",   imem_bus.addr, pc);
            chk("pc_next",     pc_next, e_next);
            chk("if_valid",    32'(if_valid), 32'(m_valid));
            chk("if_instr",    if_instr, m_instr);
            chk("if_pc",       if_pc, m_pc);
            chk("if_pc_plus4", if_pc_plus4, m_pc4);
        end
    end

    task automatic cyc(input bit r, input logic [31:0] p, input bit rv, input logic [31:0] rt,
                       input bit st, input bit ak, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst             = r;
        pc              = p;
        redirect_valid  = rv;
        redirect_target = rt;
        stall           = st;
        imem_bus.ack    = ak;
        imem_bus.rdata  = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;

        // reset
        cyc(1, 32'h123, 0, 0, 0, 0, 0);
        cyc(1, 32'h123, 0, 0, 0, 0, 0);
        chk("rst_req",     32'(imem_bus.req), 32'd0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_valid",   32'(if_valid), 32'd0);
        chk("rst_instr",   if_instr, 32'h0);

        // first cycle out of reset: idle, stray ack ignored
        cyc(0, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("idle_req",  32'(imem_bus.req), 32'd0);

        // single-cycle ack at pc=0
        cyc(0, 32'h0, 0, 0, 0, 1, 32'h2002_0005);
        chk("first_req",     32'(imem_bus.req), 32'd1);
        chk("first_pc_next", pc_next, 32'h4);
        cyc(0, 32'h4, 0, 0, 0, 0, 0);
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_instr", if_instr, 32'h2002_0005);
        chk("first_pc",    if_pc, 32'h0);
        chk("first_pc4",   if_pc_plus4, 32'h4);

        // ack delayed three cycles at pc=0x10
        for (int i = 0; i < 3; i++) cyc(0, 32'h10, 0, 0, 0, 0, 0);
        chk("wait_req",     32'(imem_bus.req), 32'd1);
        chk("wait_addr",    imem_bus.addr, 32'h10);
        chk("wait_pc_next", pc_next, 32'h10);
        cyc(0, 32'h10, 0, 0, 0, 1, 32'hAAAA_0001);
        chk("late_pc_next", pc_next, 32'h14);
        cyc(0, 32'h14, 0, 0, 0, 0, 0);
        chk("late_if_pc", if_pc, 32'h10);

        // stall with ack at pc=8 parks the response
        cyc(0, 32'h8, 0, 0, 1, 1, 32'hBBBB_0002);
        chk("stall_pc_next", pc_next, 32'hC);
        cyc(0, 32'hC, 0, 0, 1, 1, 32'hFFFF_0000);
        chk("hold_req",     32'(imem_bus.req), 32'd0);
        chk("hold_if_pc",   if_pc, 32'h10);
        chk("hold_pc_next", pc_next, 32'hC);
        cyc(0, 32'hC, 0, 0, 0, 0, 0);
        cyc(0, 32'hC, 0, 0, 0, 1, 32'hCCCC_0003);
        chk("unpark_if_pc", if_pc, 32'h8);
        chk("unpark_instr", if_instr, 32'hBBBB_0002);
        chk("resume_addr",  imem_bus.addr, 32'hC);
        chk("resume_next",  pc_next, 32'h10);
        cyc(0, 32'h10, 0, 0, 0, 0, 0);
        chk("resume_if_pc", if_pc, 32'hC);

        // redirect coincident with ack
        cyc(0, 32'h10, 1, 32'h40, 0, 1, 32'hDDDD_0004);
        chk("redir_pc_next", pc_next, 32'h40);
        cyc(0, 32'h40, 0, 0, 0, 0, 0);
        chk("redir_valid", 32'(if_valid), 32'd0);
        chk("redir_instr", if_instr, 32'h0);

        // redirect while parked and stalled
        cyc(0, 32'h40, 0, 0, 1, 1, 32'hEEEE_0005);
        cyc(0, 32'h44, 0, 0, 1, 0, 0);
        chk("park2_req", 32'(imem_bus.req), 32'd0);
        cyc(0, 32'h44, 1, 32'h40, 1, 0, 0);
        chk("hold_redir_next", pc_next, 32'h40);
        cyc(0, 32'h40, 0, 0, 1, 0, 0);
        chk("hold_redir_req",  32'(imem_bus.req), 32'd1);
        chk("hold_redir_addr", imem_bus.addr, 32'h40);
        cyc(0, 32'h40, 0, 0, 0, 0, 0);
        cyc(0, 32'h40, 0, 0, 0, 0, 0);
        chk("skid_flushed", 32'(if_valid), 32'd0);

        // pc wrap
        cyc(0, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h1234_5678);
        chk("wrap_pc_next", pc_next, 32'h0);
        cyc(0, 32'h0, 0, 0, 0, 0, 0);
        chk("wrap_pc4", if_pc_plus4, 32'h0);

        // reset mid-wait, response in the same cycle discarded
        cyc(1, 32'h8, 0, 0, 0, 1, 32'h5555_5555);
        chk("midrst_req",  32'(imem_bus.req), 32'd0);
        chk("midrst_next", pc_next, 32'h0);
        cyc(0, 32'h8, 0, 0, 0, 0, 0);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_instr", if_instr, 32'h0);
        chk("midrst_pc",    if_pc, 32'h0);
        chk("midrst_pc4",   if_pc_plus4, 32'h0);

        // reset while parked
        cyc(0, 32'h8, 0, 0, 0, 0, 0);
        cyc(0, 32'h8, 0, 0, 1, 1, 32'h7777_0007);
        cyc(1, 32'hC, 0, 0, 1, 0, 0);
        cyc(0, 32'h20, 0, 0, 0, 0, 0);
        chk("hrst_valid", 32'(if_valid), 32'd0);
        cyc(0, 32'h20, 0, 0, 0, 1, 32'h9999_0009);
        chk("hrst_next", pc_next, 32'h24);
        cyc(0, 32'h24, 0, 0, 0, 0, 0);
        chk("hrst_if_pc", if_pc, 32'h20);
        chk("hrst_instr", if_instr, 32'h9999_0009);
        cyc(0, 32'h24, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
Parameters:
REQ-001 RESET_PC, 32'h0000_0000, PC value driven on pc_next while rst is high.
REQ-002 NOP_INSTR, 32'h0000_0000, instruction word presented on if_instr whenever if_valid is 0.
Ports:
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc  input  32  current PC from the program counter register.
REQ-006 pc_next  output  32  next PC fed back to the program counter register; combinational.
REQ-007 redirect_valid  input  1  branch/jump taken; flushes the stage.
REQ-008 redirect_target  input  32  redirect destination.
REQ-009 stall  input  1  hazard unit holds the IF/ID register.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  request address; equals pc.
REQ-012 imem_ack  input  1  memory response valid; sampled only while imem_req=1.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-014 if_valid, if_instr[31:0], if_pc[31:0], if_pc_plus4[31:0]  outputs  IF/ID register contents.

Function
REQ-015 FSM states: S_IDLE, S_REQ, S_HOLD.
REQ-016 S_IDLE: imem_req=0; next state S_REQ unconditionally.
REQ-017 S_REQ: imem_req=1, imem_addr=pc; stay in S_REQ until imem_ack=1.
REQ-018 Accept = S_REQ and imem_ack and not redirect_valid.
REQ-019 On accept with stall=0: IF/ID loads {valid=1, imem_rdata, pc, pc+4}; stay in S_REQ.
REQ-020 On accept with stall=1: the response is captured into the skid buffer, IF/ID holds, and the FSM goes to S_HOLD.
REQ-021 S_HOLD: imem_req=0; when stall=0, IF/ID loads from the skid, the skid clears, and the FSM goes to S_REQ.
REQ-022 pc_next priority: redirect_valid -> redirect_target; else accept -> pc+4; else pc.
REQ-023 pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 redirect_valid in any state: IF/ID valid<=0, if_instr<=NOP_INSTR, skid cleared, FSM to S_REQ. Flush overrides stall.
REQ-025 redirect_valid with imem_ack in the same cycle: the response is discarded and pc does not advance to pc+4.
REQ-026 Any memory response in a cycle where imem_req=0 is ignored.
REQ-027 Dropping or changing imem_addr without an ack cancels the request; the memory tolerates this.
REQ-028 stall=1 with no ack and no redirect: all state holds and pc_next=pc.
REQ-029 At most one buffered instruction exists beyond IF/ID; no fetch issues while the skid is full.

Reset
REQ-030 While rst=1: pc_next=RESET_PC, imem_req=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=0, skid empty.
REQ-031 The FSM enters S_IDLE on reset; the first request issues 2 cycles after rst falls.
REQ-032 Reset asserted mid-request or in S_HOLD discards all in-flight data; reset has priority over redirect and stall.

Structure
REQ-033 Shared package fetch_pkg holds the state enum (S_IDLE/S_REQ/S_HOLD), the default NOP_INSTR, the default RESET_PC, and the INSTR_W=32 constant.
REQ-034 Sub-module fetch_skid_buf holds the one-entry {valid, instr, pc} skid register with load/clear/unload controls; the FSM and IF/ID register stay in fetch_stage.

Verification
REQ-035 Reset release, single-cycle ack, rdata=32'h2002_0005, pc=0 -> if_valid=1, if_instr=32'h2002_0005, if_pc=0, if_pc_plus4=4; pc_next=4 in the accept cycle.
REQ-036 Ack delayed 3 cycles at pc=32'h10 -> imem_req held high, imem_addr=32'h10, pc_next=32'h10 until ack, then 32'h14.
REQ-037 stall=1 while IF/ID is valid, ack at pc=8 -> FSM in S_HOLD, imem_req=0, IF/ID unchanged. Drop stall -> if_pc=8 next cycle, then fetch resumes at 32'hC.
REQ-038 redirect_valid=1, redirect_target=32'h40 coincident with ack -> pc_next=32'h40, next-cycle if_valid=0, if_instr=NOP_INSTR, and the response is not loaded.
REQ-039 redirect_valid during S_HOLD with stall=1 -> skid and IF/ID cleared, FSM in S_REQ, imem_addr follows the new pc=32'h40.
REQ-040 pc=32'hFFFF_FFFC, ack -> pc_next=0 and if_pc_plus4=0. rst asserted mid-wait -> all outputs at their reset values the next cycle.
